// File: rtl/mux_4_to_1.sv
// mux_4_to_1: registered 4-to-1 lane selector with a valid strobe.
//
// Picks one of four WIDTH-bit lanes by a 2-bit select and registers it onto
// data_out. out_valid is high for exactly the cycle after each accepted
// capture. With in_valid low, data_out holds its previous value.
//
// Ports:
//   clk       in   1        rising-edge clock
//   rst       in   1        asynchronous active-high reset; clears all state
//   data_in   in   4*WIDTH  four packed lanes, lane k = data_in[k*WIDTH +: WIDTH]
//   sel       in   2        lane select (0..3)
//   in_valid  in   1        qualifies data_in/sel for capture this cycle
//   data_out  out  WIDTH    registered selected lane
//   out_valid out  1        high the cycle after each accepted capture
module mux_4_to_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] data_in,
    input  logic [1:0]         sel,
    input  logic               in_valid,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_valid
);

    // Lanes are split out with constant slices so that the selection is a
    // plain array index on sel; an X on an unselected lane cannot reach
    // the selected value.
    logic [WIDTH-1:0] lane [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign lane[k] = data_in[k*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] selected;

    always_comb begin
        selected = lane[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= selected;
            end
        end
    end

endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: directed self-checking bench for mux_4_to_1.
//
// Drives a WIDTH=1 instance and a WIDTH=8 instance from one clock. Inputs
// change 1 time unit after posedge; outputs are sampled at the same point.
module tb_mux_4_to_1;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic [1:0] sel;
    logic       in_valid;
    logic       data_out;
    logic       out_valid;

    logic [31:0] w_data_in;
    logic [1:0]  w_sel;
    logic        w_in_valid;
    logic [7:0]  w_data_out;
    logic        w_out_valid;

    int unsigned total;
    int unsigned bad;

    mux_4_to_1 #(.WIDTH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    mux_4_to_1 #(.WIDTH(8)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .data_in   (w_data_in),
        .sel       (w_sel),
        .in_valid  (w_in_valid),
        .data_out  (w_data_out),
        .out_valid (w_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
        in_valid = v;
        sel      = s;
        data_in  = d;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst        = 1'b1;
        drive(1'b0, 2'b00, 4'b0000);
        w_data_in  = '0;
        w_sel      = 2'b00;
        w_in_valid = 1'b0;

        // Reset state
        #1;
        check("reset_data", {7'd0, data_out}, 8'h00);
        check("reset_valid", {7'd0, out_valid}, 8'h00);
        check("reset_wdata", w_data_out, 8'h00);
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("idle_valid", {7'd0, out_valid}, 8'h00);

        // Select sweep: one-hot data on the selected lane
        drive(1'b1, 2'b00, 4'b0001); tick;
        check("sweep0_data", {7'd0, data_out}, 8'h01);
        check("sweep0_valid", {7'd0, out_valid}, 8'h01);
        drive(1'b1, 2'b01, 4'b0010); tick;
        check("sweep1_data", {7'd0, data_out}, 8'h01);
        check("sweep1_valid", {7'd0, out_valid}, 8'h01);
        drive(1'b1, 2'b10, 4'b0100); tick;
        check("sweep2_data", {7'd0, data_out}, 8'h01);
        check("sweep2_valid", {7'd0, out_valid}, 8'h01);
        drive(1'b1, 2'b11, 4'b1000); tick;
        check("sweep3_data", {7'd0, data_out}, 8'h01);
        check("sweep3_valid", {7'd0, out_valid}, 8'h01);

        // Unselected-lane isolation
        drive(1'b1, 2'b00, 4'b1110); tick;
        check("iso_sel0", {7'd0, data_out}, 8'h00);
        drive(1'b1, 2'b11, 4'b0111); tick;
        check("iso_sel3", {7'd0, data_out}, 8'h00);
        drive(1'b1, 2'b10, 4'bx1xx); tick;
        check("iso_x_sel2", {7'd0, data_out}, 8'h01);
        drive(1'b1, 2'b01, 4'bxx0x); tick;
        check("iso_x_sel1", {7'd0, data_out}, 8'h00);

        // Hold: capture a 1, then three idle cycles with zero data
        drive(1'b1, 2'b10, 4'b0100); tick;
        check("hold_capture", {7'd0, data_out}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 4'b0000); tick;
            check("hold_data", {7'd0, data_out}, 8'h01);
            check("hold_valid", {7'd0, out_valid}, 8'h00);
        end

        // Back-to-back: alternate sel 00/11 on data 1000
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 4'b1000); tick;
            check("b2b_data", {7'd0, data_out}, (i % 2 == 0) ? 8'h00 : 8'h01);
            check("b2b_valid", {7'd0, out_valid}, 8'h01);
        end

        // Async reset mid-cycle with data_out = 1
        drive(1'b0, 2'b00, 4'b0000);
        #3;
        check("pre_rst_data", {7'd0, data_out}, 8'h01);
        rst = 1'b1;
        #1;
        check("async_rst_data", {7'd0, data_out}, 8'h00);
        check("async_rst_valid", {7'd0, out_valid}, 8'h00);
        drive(1'b1, 2'b11, 4'b1000);
        tick;
        tick;
        check("rst_hold_data", {7'd0, data_out}, 8'h00);
        check("rst_hold_valid", {7'd0, out_valid}, 8'h00);
        rst = 1'b0;
        drive(1'b0, 2'b11, 4'b1000); tick;
        check("post_rst_idle_data", {7'd0, data_out}, 8'h00);
        check("post_rst_idle_valid", {7'd0, out_valid}, 8'h00);
        drive(1'b1, 2'b11, 4'b1000); tick;
        check("post_rst_first_data", {7'd0, data_out}, 8'h01);
        check("post_rst_first_valid", {7'd0, out_valid}, 8'h01);
        drive(1'b0, 2'b00, 4'b0000);

        // Wide lanes
        w_data_in  = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        w_sel      = 2'b10;
        w_in_valid = 1'b1;
        tick;
        check("wide_sel2", w_data_out, 8'hCC);
        check("wide_valid", {7'd0, w_out_valid}, 8'h01);
        w_sel = 2'b01;
        tick;
        check("wide_sel1", w_data_out, 8'hBB);
        w_sel = 2'b11;
        tick;
        check("wide_sel3", w_data_out, 8'hDD);
        w_sel = 2'b00;
        tick;
        check("wide_sel0", w_data_out, 8'hAA);
        w_in_valid = 1'b0;
        w_sel      = 2'b11;
        tick;
        check("wide_hold_data", w_data_out, 8'hAA);
        check("wide_hold_valid", {7'd0, w_out_valid}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
